datapath_seq: RTL and testbench

Parametrised, self-sequencing successor to the lab datapath. It contains an NREGS x DATA_W register file, A/B/C pipeline registers, a B-operand shifter, an extended ALU and a status register. An internal FSM replaces the externally driven loada/loadb/loadc/loads/write strobes and is driven by a start/done command handshake. It sits between the future instruction decoder/controller and memory (mdata, pc).

---
 rtl/datapath_pkg.sv | 42 ++++
 rtl/datapath_seq_alu.sv | 57 +++++
 rtl/datapath_seq.sv | 166 ++++++++++++++++
 tb/tb_datapath_seq.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/datapath_pkg.sv
// Shared types and constants for the self-sequencing datapath.
package datapath_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_MVN = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_CMP = 3'd6,
    OP_MOV = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    SRC_RM    = 2'd0,
    SRC_IMM   = 2'd1,
    SRC_MDATA = 2'd2,
    SRC_PC    = 2'd3
  } src_e;

  typedef enum logic [1:0] {
    SH_NONE = 2'd0,
    SH_LSL1 = 2'd1,
    SH_LSR1 = 2'd2,
    SH_ASR1 = 2'd3
  } shift_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_A = 3'd1,
    ST_RD_B = 3'd2,
    ST_EXEC = 3'd3,
    ST_WB   = 3'd4
  } state_e;

  // Bit positions inside status_out = {V, N, Z}
  localparam int Z_BIT = 0;
  localparam int N_BIT = 1;
  localparam int V_BIT = 2;

endpackage

// File: rtl/datapath_seq_alu.sv
// Combinational B-operand shifter followed by the extended ALU and flag logic.
module alu_unit
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  shift_e            shift,
  input  op_e               op,
  output logic [DATA_W-1:0] c,
  output logic              z,
  output logic              n,
  output logic              v
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] bs;

  // Single-position shift of the B operand; ASR keeps the sign bit.
  always_comb begin
    bs = b;
    case (shift)
      SH_NONE: bs = b;
      SH_LSL1: bs = {b[MSB-1:0], 1'b0};
      SH_LSR1: bs = {1'b0, b[MSB:1]};
      SH_ASR1: bs = {b[MSB], b[MSB:1]};
      default: bs = b;
    endcase
  end

  // Operation select and flags; V only has meaning for the add/subtract family.
  always_comb begin
    c = '0;
    v = 1'b0;
    case (op)
      OP_ADD: begin
        c = a + bs;
        v = (a[MSB] == bs[MSB]) && (c[MSB] != a[MSB]);
      end
      OP_SUB, OP_CMP: begin
        c = a - bs;
        v = (a[MSB] != bs[MSB]) && (c[MSB] != a[MSB]);
      end
      OP_AND:  c = a & bs;
      OP_OR:   c = a | bs;
      OP_XOR:  c = a ^ bs;
      OP_MVN:  c = ~bs;
      OP_MOV:  c = bs;
      default: c = '0;
    endcase
    z = (c == '0);
    n = c[MSB];
  end

endmodule

// File: rtl/datapath_seq.sv
// Self-sequencing datapath: register file, A/B/C pipeline registers, status
// register and a command FSM driven by a start/done handshake.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | waiting for start; external register writes allowed
//   ST_RD_A | A <= reg[rn]
//   ST_RD_B | B <= selected source (reg[rm], sext imm, mdata, zext pc)
//   ST_EXEC | C <= ALU(A, shift(B)); status <= flags
//   ST_WB   | reg[rd] <= C (skipped for CMP); done pulses next cycle
module datapath_seq
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int IMM_W  = 8,
  parameter int PC_W   = 8,
  localparam int RA_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [1:0]        src,
  input  logic [1:0]        shift,
  input  logic [RA_W-1:0]   rd,
  input  logic [RA_W-1:0]   rn,
  input  logic [RA_W-1:0]   rm,
  input  logic [IMM_W-1:0]  imm,
  input  logic [DATA_W-1:0] mdata,
  input  logic [PC_W-1:0]   pc,
  input  logic              wr_en,
  input  logic [RA_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic [2:0]        status_out
);

  state_e state;

  op_e              op_q;
  src_e             src_q;
  shift_e           shift_q;
  logic [RA_W-1:0]  rd_q;
  logic [RA_W-1:0]  rn_q;
  logic [RA_W-1:0]  rm_q;
  logic [IMM_W-1:0] imm_q;

  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] regs [NREGS];

  logic [DATA_W-1:0] b_sel;
  logic [DATA_W-1:0] alu_c;
  logic              alu_z;
  logic              alu_n;
  logic              alu_v;

  assign dbg_data = regs[dbg_addr];

  // B operand mux; imm is sign-extended and pc zero-extended to the datapath width.
  always_comb begin
    b_sel = regs[rm_q];
    case (src_q)
      SRC_RM:    b_sel = regs[rm_q];
      SRC_IMM:   b_sel = DATA_W'($signed(imm_q));
      SRC_MDATA: b_sel = mdata;
      SRC_PC:    b_sel = DATA_W'(pc);
      default:   b_sel = regs[rm_q];
    endcase
  end

  alu_unit #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a     (a_q),
    .b     (b_q),
    .shift (shift_q),
    .op    (op_q),
    .c     (alu_c),
    .z     (alu_z),
    .n     (alu_n),
    .v     (alu_v)
  );

  // Command sequencer with its pipeline registers and handshake outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      op_q       <= OP_ADD;
      src_q      <= SRC_RM;
      shift_q    <= SH_NONE;
      rd_q       <= '0;
      rn_q       <= '0;
      rm_q       <= '0;
      imm_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result     <= '0;
      status_out <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q    <= op_e'(op);
            src_q   <= src_e'(src);
            shift_q <= shift_e'(shift);
            rd_q    <= rd;
            rn_q    <= rn;
            rm_q    <= rm;
            imm_q   <= imm;
            busy    <= 1'b1;
            state   <= ST_RD_A;
          end
        end
        ST_RD_A: begin
          a_q   <= regs[rn_q];
          state <= ST_RD_B;
        end
        ST_RD_B: begin
          b_q   <= b_sel;
          state <= ST_EXEC;
        end
        ST_EXEC: begin
          result            <= alu_c;
          status_out[Z_BIT] <= alu_z;
          status_out[N_BIT] <= alu_n;
          status_out[V_BIT] <= alu_v;
          state             <= ST_WB;
        end
        ST_WB: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Register file: FSM writeback wins; external writes land only while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (state == ST_WB) begin
      if (op_q != OP_CMP) begin
        regs[rd_q] <= result;
      end
    end else if (wr_en && (state == ST_IDLE)) begin
      regs[wr_addr] <= wr_data;
    end
  end

endmodule

// File: tb/tb_datapath_seq.sv
// Self-checking bench for datapath_seq with a behavioural reference model.
module tb_datapath_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [1:0]  src;
  logic [1:0]  shift;
  logic [2:0]  rd, rn, rm;
  logic [7:0]  imm;
  logic [15:0] mdata;
  logic [7:0]  pc;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic [2:0]  dbg_addr;
  logic [15:0] dbg_data;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic [2:0]  status_out;

  int total;
  int bad;

  int mreg [8];

  datapath_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .op         (op),
    .src        (src),
    .shift      (shift),
    .rd         (rd),
    .rn         (rn),
    .rm         (rm),
    .imm        (imm),
    .mdata      (mdata),
    .pc         (pc),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dbg_addr   (dbg_addr),
    .dbg_data   (dbg_data),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .status_out (status_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value of B after the shifter, using plain integer arithmetic.
  function automatic int ref_shift(int b, int sh);
    case (sh)
      1:       return (b * 2) % 65536;
      2:       return b / 2;
      3:       return b / 2 + ((b >= 32768) ? 32768 : 0);
      default: return b;
    endcase
  endfunction

  function automatic int to_signed16(int x);
    return (x >= 32768) ? x - 65536 : x;
  endfunction

  // Reference ALU: returns result and {V,N,Z}.
  task automatic ref_alu(input int o, input int a, input int bs, output int c, output int st);
    int s;
    int v;
    logic [15:0] la, lb;
    la = a[15:0];
    lb = bs[15:0];
    v = 0;
    case (o)
      0: begin
        c = (a + bs) % 65536;
        s = to_signed16(a) + to_signed16(bs);
        v = (s > 32767 || s < -32768) ? 1 : 0;
      end
      1, 6: begin
        c = (a - bs + 65536) % 65536;
        s = to_signed16(a) - to_signed16(bs);
        v = (s > 32767 || s < -32768) ? 1 : 0;
      end
      2: c = int'(la & lb);
      3: c = 65535 - bs;
      4: c = int'(la | lb);
      5: c = int'(la ^ lb);
      default: c = bs;
    endcase
    st = v * 4 + ((c >= 32768) ? 2 : 0) + ((c == 0) ? 1 : 0);
  endtask

  task automatic ext_write(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = addr[2:0];
    wr_data = data[15:0];
    @(posedge clk); #1;
    wr_en = 1'b0;
    mreg[addr] = data % 65536;
  endtask

  task automatic read_reg(input int addr, output int val);
    dbg_addr = addr[2:0];
    #1;
    val = int'(dbg_data);
  endtask

  // Issue one command now (caller is just past a rising edge) and wait for done.
  // lat = rising edges after the accepting edge until done is seen (-1 on timeout).
  task automatic do_cmd(input int o, input int s, input int sh, input int d, input int n_, input int m,
                        input int im, input int md, input int p,
                        output int lat, output int exp_c, output int exp_st);
    int b;
    start = 1'b1;
    op = o[2:0]; src = s[1:0]; shift = sh[1:0];
    rd = d[2:0]; rn = n_[2:0]; rm = m[2:0];
    imm = im[7:0]; mdata = md[15:0]; pc = p[7:0];
    case (s)
      0:       b = mreg[m];
      1:       b = (im >= 128) ? im + 65280 : im;
      2:       b = md;
      default: b = p;
    endcase
    ref_alu(o, mreg[n_], ref_shift(b, sh), exp_c, exp_st);
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    if (o != 6) mreg[d] = exp_c;
  endtask

  task automatic test_reset();
    int val;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_handshake: busy=%b done=%b required 0 0", busy, done);
    end
    total++;
    if (result !== 16'h0 || status_out !== 3'b000) begin
      bad++; $display("FAIL reset_outputs: result=%h status=%b required 0000 000", result, status_out);
    end
    read_reg(5, val);
    total++;
    if (val !== 0) begin
      bad++; $display("FAIL reset_reg5: got %h required 0", val);
    end
  endtask

  task automatic test_add();
    int lat, ec, es, val;
    ext_write(0, 5);
    ext_write(1, 7);
    do_cmd(0, 0, 0, 2, 0, 1, 0, 0, 0, lat, ec, es);
    total++;
    if (lat !== 4) begin
      bad++; $display("FAIL add_latency: got %0d edges required 4", lat);
    end
    total++;
    if (result !== 16'd12 || status_out !== 3'b000) begin
      bad++; $display("FAIL add_result: got %h/%b required 000c/000", result, status_out);
    end
    read_reg(2, val);
    total++;
    if (val !== 12) begin
      bad++; $display("FAIL add_wb: R2=%h required 000c", val);
    end
  endtask

  task automatic test_cmp_sub();
    int lat, ec, es, val;
    ext_write(3, 16'h1234);
    ext_write(4, 7);
    ext_write(5, 7);
    do_cmd(6, 0, 0, 3, 4, 5, 0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'h0 || status_out !== 3'b001) begin
      bad++; $display("FAIL cmp_result: got %h/%b required 0000/001", result, status_out);
    end
    read_reg(3, val);
    total++;
    if (val !== 16'h1234) begin
      bad++; $display("FAIL cmp_nowrite: R3=%h required 1234", val);
    end
    do_cmd(1, 0, 0, 0, 4, 5, 0, 0, 0, lat, ec, es);
    read_reg(0, val);
    total++;
    if (val !== 0 || status_out !== 3'b001) begin
      bad++; $display("FAIL sub_zero: R0=%h status=%b required 0000/001", val, status_out);
    end
  endtask

  task automatic test_shift();
    int lat, ec, es;
    ext_write(1, 2);
    ext_write(0, 7);
    do_cmd(0, 0, 1, 2, 1, 0, 0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'd16 || status_out !== 3'b000) begin
      bad++; $display("FAIL lsl_add: got %h/%b required 0010/000", result, status_out);
    end
    ext_write(0, 16'h8000);
    do_cmd(7, 0, 3, 6, 1, 0, 0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'hC000 || status_out !== 3'b010) begin
      bad++; $display("FAIL asr_mov: got %h/%b required c000/010", result, status_out);
    end
    do_cmd(7, 0, 2, 6, 1, 0, 0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'h4000 || status_out !== 3'b000) begin
      bad++; $display("FAIL lsr_mov: got %h/%b required 4000/000", result, status_out);
    end
  endtask

  task automatic test_overflow();
    int lat, ec, es;
    ext_write(0, 16'h7FFF);
    ext_write(1, 1);
    do_cmd(0, 0, 0, 2, 0, 1, 0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'h8000 || status_out !== 3'b110) begin
      bad++; $display("FAIL add_ovf: got %h/%b required 8000/110", result, status_out);
    end
    do_cmd(1, 0, 0, 3, 2, 1, 0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'h7FFF || status_out !== 3'b100) begin
      bad++; $display("FAIL sub_ovf: got %h/%b required 7fff/100", result, status_out);
    end
  endtask

  task automatic test_mvn_imm_pc();
    int lat, ec, es;
    ext_write(0, 14);
    do_cmd(3, 0, 0, 1, 2, 0, 0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'hFFF1 || status_out !== 3'b010) begin
      bad++; $display("FAIL mvn: got %h/%b required fff1/010", result, status_out);
    end
    do_cmd(7, 1, 0, 1, 2, 0, 8'hF0, 0, 0, lat, ec, es);
    total++;
    if (result !== 16'hFFF0) begin
      bad++; $display("FAIL imm_sext: got %h required fff0", result);
    end
    do_cmd(7, 3, 0, 1, 2, 0, 0, 0, 8'h2A, lat, ec, es);
    total++;
    if (result !== 16'h002A || status_out !== 3'b000) begin
      bad++; $display("FAIL pc_zext: got %h/%b required 002a/000", result, status_out);
    end
    do_cmd(0, 2, 0, 1, 0, 0, 0, 16'h1000, 0, lat, ec, es);
    total++;
    if (result !== 16'h100E) begin
      bad++; $display("FAIL mdata_add: got %h required 100e", result);
    end
  endtask

  task automatic test_random();
    int lat, ec, es, val, d;
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) == 0) ext_write($urandom_range(0, 7), $urandom_range(0, 65535));
      d = $urandom_range(0, 7);
      do_cmd($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3), d,
             $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 255),
             $urandom_range(0, 65535), $urandom_range(0, 255), lat, ec, es);
      total++;
      if (lat !== 4) begin
        bad++; $display("FAIL rnd_latency[%0d]: got %0d required 4", it, lat);
      end
      total++;
      if (int'(result) !== ec || int'(status_out) !== es) begin
        bad++; $display("FAIL rnd_result[%0d]: got %h/%b required %h/%b", it, result, status_out, ec[15:0], es[2:0]);
      end
      read_reg(d, val);
      total++;
      if (val !== mreg[d]) begin
        bad++; $display("FAIL rnd_reg[%0d]: R%0d=%h required %h", it, d, val, mreg[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, ec, es;
    ext_write(4, 100);
    ext_write(5, 23);
    do_cmd(0, 0, 0, 6, 4, 5, 0, 0, 0, lat1, ec, es);
    // still in the done cycle: second command depends on the first's writeback
    do_cmd(1, 0, 0, 7, 6, 5, 0, 0, 0, lat2, ec, es);
    total++;
    if (lat1 !== 4 || lat2 !== 4) begin
      bad++; $display("FAIL b2b_latency: got %0d/%0d required 4/4", lat1, lat2);
    end
    total++;
    if (result !== 16'd100) begin
      bad++; $display("FAIL b2b_result: got %h required 0064", result);
    end
  endtask

  task automatic test_busy_ignore();
    int val, seen, idle_busy;
    ext_write(6, 100);
    ext_write(7, 3);
    start = 1'b1; op = 3'd0; src = 2'd0; shift = 2'd0; rd = 3'd5; rn = 3'd6; rm = 3'd7;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op = 3'd7; rd = 3'd4; src = 2'd1; imm = 8'h55;
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'd999;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    seen = 0;
    for (int k = 0; k < 10 && seen == 0; k++) begin
      @(posedge clk); #1;
      if (done) seen = 1;
    end
    total++;
    if (seen !== 1 || result !== 16'd103) begin
      bad++; $display("FAIL busy_cmd: done_seen=%0d result=%h required 1/0067", seen, result);
    end
    mreg[5] = 103;
    @(posedge clk); #1;
    idle_busy = busy;
    total++;
    if (idle_busy !== 0) begin
      bad++; $display("FAIL start_not_queued: busy=%0d required 0", idle_busy);
    end
    read_reg(6, val);
    total++;
    if (val !== 100) begin
      bad++; $display("FAIL wr_dropped: R6=%h required 0064", val);
    end
    read_reg(4, val);
    total++;
    if (val !== mreg[4]) begin
      bad++; $display("FAIL ignored_start_wb: R4=%h required %h", val, mreg[4]);
    end
  endtask

  task automatic test_reset_midop();
    int seen, val, nz;
    ext_write(1, 9);
    start = 1'b1; op = 3'd0; src = 2'd0; shift = 2'd0; rd = 3'd2; rn = 3'd1; rm = 3'd1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 8; i++) mreg[i] = 0;
    total++;
    if (busy !== 1'b0 || result !== 16'h0 || status_out !== 3'b000) begin
      bad++; $display("FAIL midop_reset: busy=%b result=%h status=%b required 0/0000/000", busy, result, status_out);
    end
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (done) seen = 1;
      @(posedge clk); #1;
    end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL midop_no_done: done seen=%0d required 0", seen);
    end
    nz = 0;
    for (int i = 0; i < 8; i++) begin
      read_reg(i, val);
      if (val != 0) nz++;
    end
    total++;
    if (nz !== 0) begin
      bad++; $display("FAIL midop_regs: %0d nonzero registers required 0", nz);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; op = '0; src = '0; shift = '0;
    rd = '0; rn = '0; rm = '0; imm = '0; mdata = '0; pc = '0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; dbg_addr = '0;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_cmp_sub();
    test_shift();
    test_overflow();
    test_mvn_imm_pc();
    test_back_to_back();
    test_busy_ignore();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
